rv32i_writeback: RTL and testbench
==================================

# rv32i_writeback

Stage-5 writeback controller for the RV32I pipeline. It is the write-side counterpart of the integer base register file: it accepts completed results from the memory stage and drives the register file's write port (`rd` address, `rd` data, write enable). For loads, it waits for the data-memory acknowledge, then aligns and sign- or zero-extends the returned word. It stalls the pipeline while a load is outstanding.

## Interface
- `ACK_TIMEOUT`, default 15: maximum cycles spent waiting for `i_ack` before aborting the load. Used only when the timeout is compiled in.
- `i_clk` in, 1: clock.
- `i_rst` in, 1: synchronous, active-high reset.
- `i_ce` in, 1: memory stage presents a valid instruction this cycle.
- `i_flush` in, 1: kill the current or pending instruction.
- `i_wr_rd` in, 1: instruction writes `rd`.
- `i_rd_addr` in, 5: destination register.
- `i_is_load` in, 1: instruction is a load.
- `i_funct3` in, 3: load type.
- `i_addr_lsb` in, 2: byte offset of the load address.
- `i_alu_rd` in, 32: non-load result.
- `i_din` in, 32: data-memory read word.
- `i_ack` in, 1: data-memory read complete.
- `o_wr_rd` out, 1: register file write enable.
- `o_rd_addr` out, 5: register file write address.
- `o_rd` out, 32: register file write data.
- `o_stall` out, 1: freeze upstream stages.
- `o_err` out, 1: one-cycle load-timeout pulse.

## Operation
- States: IDLE and WAIT_ACK.
- IDLE, `i_ce`=1, `i_flush`=0, `i_is_load`=0:
  - Register `o_rd`=`i_alu_rd` and `o_rd_addr`=`i_rd_addr`.
  - Register `o_wr_rd`=`i_wr_rd` && (`i_rd_addr`!=0).
- IDLE, `i_ce`=1, `i_flush`=0, `i_is_load`=1:
  - Latch `rd_addr`, `wr_rd`, `funct3` and `addr_lsb`.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - `i_ce` is ignored.
  - On `i_ack`=1: drive the aligned `i_din` onto `o_rd`, assert `o_wr_rd` per the latched `wr_rd` and `rd`!=0, and return to IDLE.
- Load alignment (`funct3`):
  - 000 LB: byte [`lsb`*8 +: 8], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half [`lsb`[1]*16 +: 16], sign-extended.
  - 101 LHU: same half, zero-extended.
  - 010 LW, and any other code: full word.
- Flush:
  - In IDLE, suppresses acceptance, so no write and no state change.
  - In WAIT_ACK, returns to IDLE with no write; a late `i_ack` is ignored.
  - Flush has priority over `i_ack` in the same cycle.
- `o_wr_rd` is never asserted for `rd_addr`=0.

## Timing
- Reset values: `o_wr_rd`=0, `o_rd_addr`=0, `o_rd`=0, `o_stall`=0, `o_err`=0, state IDLE, timeout counter 0.
- Non-load: `o_wr_rd`, `o_rd_addr` and `o_rd` are valid exactly 1 cycle after the `i_ce` cycle, as a single-cycle pulse.
- Load:
  - `o_stall` is registered and is high from the cycle after acceptance until the cycle after `i_ack` is seen.
  - The write pulse occurs 1 cycle after the `i_ack` cycle.
  - If `i_ack` arrives in the first WAIT_ACK cycle, the minimum load latency is 2 cycles.
- `o_wr_rd` is deasserted in every cycle with no completion.
- Back-to-back non-loads on consecutive `i_ce` cycles produce consecutive write pulses.
- `i_rst` mid-load: IDLE next cycle, no write, `o_stall`=0.

## Configuration
- `RV32I_WB_TIMEOUT_EN` defined:
  - A counter of `$clog2(ACK_TIMEOUT+1)` bits increments each WAIT_ACK cycle without `i_ack`.
  - When it reaches `ACK_TIMEOUT`, the block pulses `o_err` for one cycle, suppresses the write, clears `o_stall` and returns to IDLE.
  - The counter clears on entry to WAIT_ACK.
- `RV32I_WB_TIMEOUT_EN` undefined:
  - No counter; WAIT_ACK holds indefinitely.
  - `o_err` is tied to 0.

## Structure
- Shared package `rv32i_pkg`:
  - Load `funct3` constants: LB, LH, LW, LBU, LHU.
  - `wb_state_t` enum: IDLE, WAIT_ACK.
- Sub-module `rv32i_load_align`: purely combinational (`i_din`, `funct3`, `addr_lsb` → 32-bit result), reusable by the memory stage.

## Test plan
- Non-load with `rd`=5, `i_alu_rd`=0xDEADBEEF, `i_wr_rd`=1 → next cycle `o_wr_rd`=1, `o_rd_addr`=5, `o_rd`=0xDEADBEEF; `o_wr_rd`=0 the cycle after.
- Non-load with `rd`=0 and `i_wr_rd`=1 → `o_wr_rd` stays 0.
- LB, `lsb`=2, `i_din`=0x0080FF00, `i_ack` 3 cycles after acceptance:
  - `o_stall` high through the ack cycle.
  - Write pulse of 0xFFFFFF80 the following cycle.
  - Repeating as LBU gives 0x00000080.
- LH, `lsb`=2, `i_din`=0x8001_1234 → `o_rd`=0xFFFF8001; LHU → 0x00008001.
- LW outstanding, then `i_flush` and `i_ack` in the same cycle → no write, IDLE next cycle, `o_stall`=0.
- `RV32I_WB_TIMEOUT_EN` defined, `ACK_TIMEOUT`=4, no ack → `o_err` pulses once after 4 WAIT_ACK cycles, no write, `o_stall` drops.
- `i_rst` asserted mid-load → all outputs at reset values and no write.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: load funct3 encodings and writeback FSM states.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } wb_state_t;

endpackage

// File: rtl/rv32i_load_align.sv
// Combinational load data alignment with sign/zero extension.
module rv32i_load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] i_din,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lsb,
    output logic [31:0] o_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = i_din[{i_addr_lsb, 3'b000} +: 8];
        half_sel = i_addr_lsb[1] ? i_din[31:16] : i_din[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  o_data = {24'h0, byte_sel};
            F3_LH:   o_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  o_data = {16'h0, half_sel};
            default: o_data = i_din;
        endcase
    end

endmodule

// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: drives the regfile write port, waits on load acks.
// Optional load-ack timeout enabled by defining RV32I_WB_TIMEOUT_EN.
module rv32i_writeback
    import rv32i_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_flush,
    input  logic        i_wr_rd,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_is_load,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lsb,
    input  logic [31:0] i_alu_rd,
    input  logic [31:0] i_din,
    input  logic        i_ack,
    output logic        o_wr_rd,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd,
    output logic        o_stall,
    output logic        o_err
);

    wb_state_t   state_q, state_d;
    logic        wr_q, wr_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_q, rd_d;
    logic        stall_q, stall_d;
    logic        err_q, err_d;
    logic        ld_wr_q, ld_wr_d;
    logic [4:0]  ld_addr_q, ld_addr_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_lsb_q, ld_lsb_d;
    logic [31:0] ld_data;

`ifdef RV32I_WB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (ACK_TIMEOUT == 0);
`endif

    rv32i_load_align u_align (
        .i_din      (i_din),
        .i_funct3   (ld_f3_q),
        .i_addr_lsb (ld_lsb_q),
        .o_data     (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        wr_d      = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_d      = rd_q;
        err_d     = 1'b0;
        ld_wr_d   = ld_wr_q;
        ld_addr_d = ld_addr_q;
        ld_f3_d   = ld_f3_q;
        ld_lsb_d  = ld_lsb_q;
`ifdef RV32I_WB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_ce && !i_flush) begin
                    if (i_is_load) begin
                        ld_wr_d   = i_wr_rd;
                        ld_addr_d = i_rd_addr;
                        ld_f3_d   = i_funct3;
                        ld_lsb_d  = i_addr_lsb;
                        state_d   = WAIT_ACK;
`ifdef RV32I_WB_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end else begin
                        rd_d      = i_alu_rd;
                        rd_addr_d = i_rd_addr;
                        wr_d      = i_wr_rd && (i_rd_addr != 5'd0);
                    end
                end
            end
            WAIT_ACK: begin
                // Flush wins over a same-cycle ack.
                if (i_flush) begin
                    state_d = IDLE;
                end else if (i_ack) begin
                    rd_d      = ld_data;
                    rd_addr_d = ld_addr_q;
                    wr_d      = ld_wr_q && (ld_addr_q != 5'd0);
                    state_d   = IDLE;
                end
`ifdef RV32I_WB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
        endcase
        stall_d = (state_d == WAIT_ACK);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_q      <= 32'd0;
            stall_q   <= 1'b0;
            err_q     <= 1'b0;
            ld_wr_q   <= 1'b0;
            ld_addr_q <= 5'd0;
            ld_f3_q   <= 3'd0;
            ld_lsb_q  <= 2'd0;
`ifdef RV32I_WB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_addr_q <= rd_addr_d;
            rd_q      <= rd_d;
            stall_q   <= stall_d;
            err_q     <= err_d;
            ld_wr_q   <= ld_wr_d;
            ld_addr_q <= ld_addr_d;
            ld_f3_q   <= ld_f3_d;
            ld_lsb_q  <= ld_lsb_d;
`ifdef RV32I_WB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign o_wr_rd   = wr_q;
    assign o_rd_addr = rd_addr_q;
    assign o_rd      = rd_q;
    assign o_stall   = stall_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_rv32i_writeback.sv
// Directed self-checking bench for rv32i_writeback.
module tb_rv32i_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        flush;
    logic        wr_rd;
    logic [4:0]  rd_addr;
    logic        is_load;
    logic [2:0]  funct3;
    logic [1:0]  addr_lsb;
    logic [31:0] alu_rd;
    logic [31:0] din;
    logic        ack;
    logic        o_wr_rd;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd;
    logic        o_stall;
    logic        o_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rv32i_writeback #(.ACK_TIMEOUT(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ce       (ce),
        .i_flush    (flush),
        .i_wr_rd    (wr_rd),
        .i_rd_addr  (rd_addr),
        .i_is_load  (is_load),
        .i_funct3   (funct3),
        .i_addr_lsb (addr_lsb),
        .i_alu_rd   (alu_rd),
        .i_din      (din),
        .i_ack      (ack),
        .o_wr_rd    (o_wr_rd),
        .o_rd_addr  (o_rd_addr),
        .o_rd       (o_rd),
        .o_stall    (o_stall),
        .o_err      (o_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ce = 0; flush = 0; wr_rd = 0; rd_addr = 0; is_load = 0;
        funct3 = 0; addr_lsb = 0; alu_rd = 0; din = 0; ack = 0;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1;
        tick(); tick();
        rst = 0;
        total++; if (o_wr_rd !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b exp=0", o_wr_rd); end
        total++; if (o_rd_addr !== 5'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", o_rd_addr); end
        total++; if (o_rd !== 32'd0) begin bad++; $display("FAIL rst_rd got=%h exp=0", o_rd); end
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", o_stall); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", o_err); end
    endtask

    task automatic test_nonload();
        ce = 1; wr_rd = 1; rd_addr = 5; alu_rd = 32'hDEADBEEF;
        tick();
        quiet();
        total++; if (o_wr_rd !== 1'b1) begin bad++; $display("FAIL nl_wr got=%b exp=1", o_wr_rd); end
        total++; if (o_rd_addr !== 5'd5) begin bad++; $display("FAIL nl_addr got=%0d exp=5", o_rd_addr); end
        total++; if (o_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL nl_rd got=%h exp=deadbeef", o_rd); end
        tick();
        total++; if (o_wr_rd !== 1'b0) begin bad++; $display("FAIL nl_pulse got=%b exp=0", o_wr_rd); end
    endtask

    task automatic test_rd0();
        ce = 1; wr_rd = 1; rd_addr = 0; alu_rd = 32'h12345678;
        tick();
        quiet();
        total++; if (o_wr_rd !== 1'b0) begin bad++; $display("FAIL rd0_wr got=%b exp=0", o_wr_rd); end
        ce = 1; wr_rd = 0; rd_addr = 8; alu_rd = 32'h1;
        tick();
        quiet();
        total++; if (o_wr_rd !== 1'b0) begin bad++; $display("FAIL nowr_wr got=%b exp=0", o_wr_rd); end
    endtask

    task automatic test_back_to_back();
        ce = 1; wr_rd = 1; rd_addr = 3; alu_rd = 32'h0000_0011;
        tick();
        total++; if (o_wr_rd !== 1'b1 || o_rd_addr !== 5'd3 || o_rd !== 32'h11) begin
            bad++; $display("FAIL b2b_a got=%b/%0d/%h exp=1/3/00000011", o_wr_rd, o_rd_addr, o_rd);
        end
        rd_addr = 4; alu_rd = 32'h0000_0022;
        tick();
        quiet();
        total++; if (o_wr_rd !== 1'b1 || o_rd_addr !== 5'd4 || o_rd !== 32'h22) begin
            bad++; $display("FAIL b2b_b got=%b/%0d/%h exp=1/4/00000022", o_wr_rd, o_rd_addr, o_rd);
        end
        tick();
        total++; if (o_wr_rd !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", o_wr_rd); end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3,
                             input logic [1:0] lsb, input logic [31:0] data,
                             input int delay, input logic [31:0] exp);
        ce = 1; is_load = 1; wr_rd = 1; rd_addr = 7; funct3 = f3; addr_lsb = lsb;
        tick();
        is_load = 0; alu_rd = 32'h5555_5555; rd_addr = 12; funct3 = 0; addr_lsb = 0;
        for (int i = 1; i < delay; i++) begin
            total++; if (o_stall !== 1'b1 || o_wr_rd !== 1'b0) begin
                bad++; $display("FAIL %s_wait stall/wr got=%b/%b exp=1/0", name, o_stall, o_wr_rd);
            end
            tick();
        end
        total++; if (o_stall !== 1'b1 || o_wr_rd !== 1'b0) begin
            bad++; $display("FAIL %s_ackcyc stall/wr got=%b/%b exp=1/0", name, o_stall, o_wr_rd);
        end
        ce = 0; ack = 1; din = data;
        tick();
        quiet();
        total++; if (o_wr_rd !== 1'b1 || o_rd_addr !== 5'd7) begin
            bad++; $display("FAIL %s_wr wr/addr got=%b/%0d exp=1/7", name, o_wr_rd, o_rd_addr);
        end
        total++; if (o_rd !== exp) begin bad++; $display("FAIL %s_data got=%h exp=%h", name, o_rd, exp); end
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL %s_stall_end got=%b exp=0", name, o_stall); end
        tick();
        total++; if (o_wr_rd !== 1'b0) begin bad++; $display("FAIL %s_pulse got=%b exp=0", name, o_wr_rd); end
    endtask

    task automatic test_flush_ack();
        ce = 1; is_load = 1; wr_rd = 1; rd_addr = 10; funct3 = 3'b010;
        tick();
        quiet();
        tick();
        flush = 1; ack = 1; din = 32'hCAFEF00D;
        tick();
        quiet();
        total++; if (o_wr_rd !== 1'b0 || o_stall !== 1'b0) begin
            bad++; $display("FAIL fl_ack wr/stall got=%b/%b exp=0/0", o_wr_rd, o_stall);
        end
        ack = 1; din = 32'hCAFEF00D;
        tick();
        quiet();
        total++; if (o_wr_rd !== 1'b0) begin bad++; $display("FAIL late_ack got=%b exp=0", o_wr_rd); end
        ce = 1; wr_rd = 1; rd_addr = 9; alu_rd = 32'hA5;
        tick();
        quiet();
        total++; if (o_wr_rd !== 1'b1 || o_rd_addr !== 5'd9 || o_rd !== 32'hA5) begin
            bad++; $display("FAIL fl_idle_after got=%b/%0d/%h exp=1/9/000000a5", o_wr_rd, o_rd_addr, o_rd);
        end
    endtask

    task automatic test_flush_idle();
        ce = 1; flush = 1; wr_rd = 1; rd_addr = 6; alu_rd = 32'h66;
        tick();
        quiet();
        total++; if (o_wr_rd !== 1'b0 || o_rd_addr !== 5'd9 || o_stall !== 1'b0) begin
            bad++; $display("FAIL fl_idle got=%b/%0d/%b exp=0/9/0", o_wr_rd, o_rd_addr, o_stall);
        end
        ce = 1; flush = 1; is_load = 1; wr_rd = 1; rd_addr = 6;
        tick();
        quiet();
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL fl_idle_load got=%b exp=0", o_stall); end
    endtask

    task automatic test_timeout();
        ce = 1; is_load = 1; wr_rd = 1; rd_addr = 11; funct3 = 3'b010;
        tick();
        quiet();
`ifdef RV32I_WB_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) begin
            total++; if (o_err !== 1'b0 || o_stall !== 1'b1) begin
                bad++; $display("FAIL to_wait%0d err/stall got=%b/%b exp=0/1", i, o_err, o_stall);
            end
            tick();
        end
        total++; if (o_err !== 1'b1 || o_stall !== 1'b0 || o_wr_rd !== 1'b0) begin
            bad++; $display("FAIL to_fire err/stall/wr got=%b/%b/%b exp=1/0/0", o_err, o_stall, o_wr_rd);
        end
        tick();
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b exp=0", o_err); end
`else
        for (int i = 0; i < 20; i++) tick();
        total++; if (o_err !== 1'b0 || o_stall !== 1'b1) begin
            bad++; $display("FAIL noto_hold err/stall got=%b/%b exp=0/1", o_err, o_stall);
        end
        flush = 1;
        tick();
        quiet();
        total++; if (o_stall !== 1'b0 || o_wr_rd !== 1'b0) begin
            bad++; $display("FAIL noto_flush stall/wr got=%b/%b exp=0/0", o_stall, o_wr_rd);
        end
`endif
    endtask

    task automatic test_reset_midload();
        ce = 1; is_load = 1; wr_rd = 1; rd_addr = 13; funct3 = 3'b000;
        tick();
        quiet();
        tick();
        rst = 1; ack = 1; din = 32'h000000FF;
        tick();
        total++; if (o_wr_rd !== 1'b0 || o_rd_addr !== 5'd0 || o_rd !== 32'd0 || o_stall !== 1'b0 || o_err !== 1'b0) begin
            bad++; $display("FAIL rst_mid got=%b/%0d/%h/%b/%b exp=0/0/0/0/0", o_wr_rd, o_rd_addr, o_rd, o_stall, o_err);
        end
        rst = 0;
        tick();
        quiet();
        total++; if (o_wr_rd !== 1'b0 || o_stall !== 1'b0) begin
            bad++; $display("FAIL rst_mid_after wr/stall got=%b/%b exp=0/0", o_wr_rd, o_stall);
        end
    endtask

    initial begin
        test_reset();
        test_nonload();
        test_rd0();
        test_back_to_back();
        test_load("lb",   3'b000, 2'd2, 32'h0080FF00, 3, 32'hFFFFFF80);
        test_load("lbu",  3'b100, 2'd2, 32'h0080FF00, 3, 32'h00000080);
        test_load("lb1",  3'b000, 2'd1, 32'h0080FF00, 2, 32'hFFFFFFFF);
        test_load("lb3",  3'b000, 2'd3, 32'h7F000000, 1, 32'h0000007F);
        test_load("lh",   3'b001, 2'd2, 32'h80011234, 2, 32'hFFFF8001);
        test_load("lhu",  3'b101, 2'd2, 32'h80011234, 2, 32'h00008001);
        test_load("lh0",  3'b001, 2'd0, 32'h80011234, 1, 32'h00001234);
        test_load("lw",   3'b010, 2'd0, 32'h12345678, 1, 32'h12345678);
        test_load("f3x",  3'b111, 2'd1, 32'h89ABCDEF, 1, 32'h89ABCDEF);
        test_flush_ack();
        test_flush_idle();
        test_timeout();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
